mips16_imem_loader: RTL and testbench
=====================================

// Module: mips16_imem_loader
// PURPOSE
//   Writable instruction memory for the 16-bit single-cycle MIPS core.
//   Replaces the fixed ROM directly upstream of decode. A host streams a
//   program in over byte pins. The core is held in reset while loading,
//   then restarts at PC 0. When not loading, it serves instruction[15:0]
//   to the core from pc_in.
// PARAMETERS
//   DEPTH     16       instruction words stored (power of 2)
//   ADDR_W    4        log2(DEPTH)
//   NOP_WORD  16'h5000 reset/fill word (JUMP 0: core spins at PC 0)
// PORTS
//   clk          in   1         core clock
//   rst_n        in   1         async active-low reset
//   load_mode    in   1         host: 1 = loading session (async pin)
//   byte_strobe  in   1         host: rising edge = byte_in valid (async pin)
//   byte_in      in   8         host data; stable >=3 clk around strobe edge
//   pc_in        in   16        core PC (byte address, step 2)
//   instruction  out  16        word to decode
//   cpu_rst_n    out  1         active-low reset to core
//   loading      out  1         1 in any load state
//   load_done    out  1         1-cycle pulse on session end
//   word_count   out  ADDR_W+1  words written in current/last session
//   err_partial  out  1         sticky: session ended mid-word
//   err_overflow out  1         sticky: strobe received with memory full
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     - State = RUN; mem[*] = NOP_WORD; word_count = 0.
//     - Both err flags = 0; load_done = 0.
//     - cpu_rst_n = 0; released 1 clk after rst_n deasserts.
//     - Reset mid-session aborts the session and discards loaded words.
//   Input sync: load_mode and byte_strobe each pass a 2-flop synchronizer.
//     - sedge = synced strobe 0->1. byte_in is sampled in the sedge cycle.
//   Read port (combinational):
//     - RUN: instruction = mem[pc_in[ADDR_W:1]] if pc_in < 2*DEPTH, else 0.
//     - Load states: instruction = NOP_WORD.
//   FSM (loading = 1 outside RUN; cpu_rst_n = 0 outside RUN):
//     RUN:
//       - On synced load_mode rise -> WAIT_HI.
//       - Clear word_count, wr_ptr and both err flags.
//     WAIT_HI:
//       - On sedge: hi_q <= byte_in -> WAIT_LO.
//     WAIT_LO:
//       - On sedge: mem[wr_ptr] <= {hi_q, byte_in}; wr_ptr++; word_count++.
//       - Go to FULL if word_count reaches DEPTH, else WAIT_HI.
//     FULL:
//       - sedge sets err_overflow; data is ignored; memory is unchanged.
//     Exit (any load state):
//       - Synced load_mode = 0 -> RUN; load_done pulses 1 clk.
//       - Exit from WAIT_LO sets err_partial; hi_q is discarded.
//       - Unwritten words keep prior contents.
//   On the exit clock, cpu_rst_n stays 0 for 1 more clk. The core therefore
//     always restarts at PC 0 with cleared registers.
//   Simultaneous exit and sedge in one cycle: exit wins; the byte is ignored.
//   word_count saturates at DEPTH. Byte order is big-endian: high byte first.
//   In RUN, strobes are ignored. A strobe needs synced strobe low >=1 clk
//     before the next edge counts.
// TESTING
//   - Reset: 4 clk reset -> mem all 16'h5000; instruction@pc 0 = 16'h5000;
//     cpu_rst_n high 1 clk after release.
//   - Load 3 words (12,34 / AB,CD / 00,01) then drop load_mode:
//     - word_count = 3; load_done pulses once.
//     - pc 0/2/4 -> 1234/ABCD/0001; pc 6 -> 16'h5000.
//   - 33 bytes: after 16 words, state FULL, err_overflow = 1, word_count = 16.
//     - mem[15] = word 16; the 33rd byte changes nothing.
//   - 5 bytes then exit: word_count = 2; err_partial = 1; mem[2] keeps old
//     value.
//   - Drop load_mode in the same cycle as a sedge in WAIT_LO: word not
//     written; err_partial = 1.
//   - rst_n low mid-session: immediate RUN, mem back to 16'h5000, flags
//     clear; pc 32 -> instruction 0.

Source files
------------

// File: rtl/mips16_imem_loader.sv
// mips16_imem_loader: host-loadable instruction memory feeding MIPS16 decode
module mips16_imem_loader #(
  parameter int          DEPTH    = 16,
  parameter int          ADDR_W   = 4,
  parameter logic [15:0] NOP_WORD = 16'h5000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load_mode,
  input  logic              i_byte_strobe,
  input  logic [7:0]        i_byte_in,
  input  logic [15:0]       i_pc_in,
  output logic [15:0]       o_instruction,
  output logic              o_cpu_rst_n,
  output logic              o_loading,
  output logic              o_load_done,
  output logic [ADDR_W:0]   o_word_count,
  output logic              o_err_partial,
  output logic              o_err_overflow
);
  typedef enum logic [1:0] {RUN, WAIT_HI, WAIT_LO, FULL} state_t;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  state_t              r_state;
  logic [1:0]          r_lm_s, r_st_s;
  logic                r_lm_d, r_st_d;
  logic [7:0]          r_hi;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W:0]     r_word_count;
  logic [15:0]         r_mem [DEPTH];
  logic                r_cpu_rst_n, r_load_done, r_err_partial, r_err_overflow;
  logic                w_lm, w_lm_rise, w_sedge, w_in_range, w_unused;
  logic [ADDR_W:0]     w_count_inc;
  assign w_lm        = r_lm_s[1];
  assign w_lm_rise   = w_lm & ~r_lm_d;
  assign w_sedge     = r_st_s[1] & ~r_st_d;
  assign w_in_range  = ~|i_pc_in[15:ADDR_W+1];
  assign w_unused    = i_pc_in[0];
  assign w_count_inc = r_word_count + 1'b1;
  assign o_instruction  = (r_state != RUN) ? NOP_WORD : (w_in_range ? r_mem[i_pc_in[ADDR_W:1]] : 16'h0000);
  assign o_loading      = (r_state != RUN);
  assign o_cpu_rst_n    = r_cpu_rst_n;
  assign o_load_done    = r_load_done;
  assign o_word_count   = r_word_count;
  assign o_err_partial  = r_err_partial;
  assign o_err_overflow = r_err_overflow;
  // two-flop synchronizers for the host pins plus delayed copies for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_lm_s <= 2'b00;
      r_st_s <= 2'b00;
      r_lm_d <= 1'b0;
      r_st_d <= 1'b0;
    end else begin
      r_lm_s <= {r_lm_s[0], i_load_mode};
      r_st_s <= {r_st_s[0], i_byte_strobe};
      r_lm_d <= r_lm_s[1];
      r_st_d <= r_st_s[1];
    end
  // load session FSM: assembles big-endian words, writes memory, holds the core in reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state        <= RUN;
      r_hi           <= 8'h00;
      r_wr_ptr       <= '0;
      r_word_count   <= '0;
      r_cpu_rst_n    <= 1'b0;
      r_load_done    <= 1'b0;
      r_err_partial  <= 1'b0;
      r_err_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= NOP_WORD;
    end else begin
      r_load_done <= 1'b0;
      if (r_state == RUN) begin
        r_cpu_rst_n <= ~w_lm_rise;
        if (w_lm_rise) begin
          r_state        <= WAIT_HI;
          r_wr_ptr       <= '0;
          r_word_count   <= '0;
          r_err_partial  <= 1'b0;
          r_err_overflow <= 1'b0;
        end
      end else begin
        r_cpu_rst_n <= 1'b0;
        if (!w_lm) begin
          r_state     <= RUN;
          r_load_done <= 1'b1;
          if (r_state == WAIT_LO) r_err_partial <= 1'b1;
        end else if (w_sedge) begin
          if (r_state == WAIT_HI) begin
            r_hi    <= i_byte_in;
            r_state <= WAIT_LO;
          end else if (r_state == WAIT_LO) begin
            r_mem[r_wr_ptr] <= {r_hi, i_byte_in};
            r_wr_ptr        <= r_wr_ptr + 1'b1;
            r_word_count    <= w_count_inc;
            r_state         <= (w_count_inc == FULL_CNT) ? FULL : WAIT_HI;
          end else begin
            r_err_overflow <= 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_mips16_imem_loader.sv
// tb_mips16_imem_loader: randomized loader sessions checked against a host-level memory model
module tb_mips16_imem_loader;
  localparam logic [15:0] NOP = 16'h5000;
  logic        clk = 1'b0, rst_n = 1'b1, load_mode = 1'b0, byte_strobe = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic [15:0] pc_in = 16'h0000;
  logic [15:0] instruction;
  logic        cpu_rst_n, loading, load_done, err_partial, err_overflow;
  logic [4:0]  word_count;

  mips16_imem_loader dut (
    .clk(clk), .rst_n(rst_n), .i_load_mode(load_mode), .i_byte_strobe(byte_strobe),
    .i_byte_in(byte_in), .i_pc_in(pc_in), .o_instruction(instruction), .o_cpu_rst_n(cpu_rst_n),
    .o_loading(loading), .o_load_done(load_done), .o_word_count(word_count),
    .o_err_partial(err_partial), .o_err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { string name; int sel; logic [31:0] exp; } probe_t;
  typedef struct { logic [4:0] wc; logic ep; logic eo; } done_t;
  probe_t pq[$];
  done_t  dq[$];
  int n_vec = 0, n_err = 0;

  // host-level reference: memory image, words written, pending high byte, overflow
  logic [15:0] m_mem [16];
  int          m_wc;
  logic        m_eo, m_have_hi;
  logic [7:0]  m_hi;

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      0: return 32'(instruction);
      1: return 32'(cpu_rst_n);
      2: return 32'(loading);
      3: return 32'(load_done);
      4: return 32'(word_count);
      5: return 32'(err_partial);
      6: return 32'(err_overflow);
      7: return 32'(dq.size());
      default: return 32'hdead_beef;
    endcase
  endfunction

  // monitor: pops session-end results on load_done, and pending probes every cycle
  always @(negedge clk) begin : mon
    done_t d;
    probe_t p;
    logic [31:0] act;
    if (load_done === 1'b1) begin
      n_vec++;
      if (dq.size() == 0) begin
        n_err++;
        $display("FAIL load_done: got unexpected pulse, required no pulse");
      end else begin
        d = dq.pop_front();
        if ({word_count, err_partial, err_overflow} !== {d.wc, d.ep, d.eo}) begin
          n_err++;
          $display("FAIL session_end: got wc=%0d ep=%b eo=%b, required wc=%0d ep=%b eo=%b",
                   word_count, err_partial, err_overflow, d.wc, d.ep, d.eo);
        end
      end
    end
    while (pq.size() != 0) begin
      p = pq.pop_front();
      act = sample(p.sel);
      n_vec++;
      if (act !== p.exp) begin
        n_err++;
        $display("FAIL %s: got %0h, required %0h", p.name, act, p.exp);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic want(input string nm, input int sel, input logic [31:0] e);
    probe_t p;
    p.name = nm;
    p.sel  = sel;
    p.exp  = e;
    pq.push_back(p);
  endtask

  function automatic logic [15:0] m_rd(input int pc);
    return (pc < 32) ? m_mem[pc / 2] : 16'h0000;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = NOP;
    m_wc = 0;
    m_eo = 1'b0;
    m_have_hi = 1'b0;
    m_hi = 8'h00;
  endfunction

  task automatic rd(input int pc);
    pc_in = 16'(pc);
    want($sformatf("instr@%0d", pc), 0, 32'(m_rd(pc)));
    tick(1);
  endtask

  task automatic enter();
    load_mode = 1'b1;
    tick(4);
    m_wc = 0;
    m_eo = 1'b0;
    m_have_hi = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] b);
    byte_in = b;
    byte_strobe = 1'b1;
    tick(4);
    byte_strobe = 1'b0;
    tick(4);
  endtask

  task automatic send(input logic [7:0] b);
    pulse(b);
    if (m_wc == 16) m_eo = 1'b1;
    else if (m_have_hi) begin
      m_mem[m_wc] = {m_hi, b};
      m_wc++;
      m_have_hi = 1'b0;
    end else begin
      m_hi = b;
      m_have_hi = 1'b1;
    end
  endtask

  task automatic exit_session();
    load_mode = 1'b0;
    dq.push_back('{5'(m_wc), m_have_hi, m_eo});
    m_have_hi = 1'b0;
    tick(6);
    want("exit_loading", 2, 0);
    want("exit_cpu_rst_n", 1, 1);
    tick(1);
  endtask

  task automatic exit_with_strobe(input logic [7:0] b);
    byte_in = b;
    byte_strobe = 1'b1;
    load_mode = 1'b0;
    dq.push_back('{5'(m_wc), m_have_hi, m_eo});
    m_have_hi = 1'b0;
    tick(4);
    byte_strobe = 1'b0;
    tick(4);
    want("exitsb_loading", 2, 0);
  endtask

  initial begin
    m_reset();
    #2 rst_n = 1'b0;
    tick(4);
    want("rst_cpu_rst_n", 1, 0);
    want("rst_instr0", 0, 32'(NOP));
    want("rst_wc", 4, 0);
    want("rst_ep", 5, 0);
    want("rst_eo", 6, 0);
    want("rst_done", 3, 0);
    want("rst_loading", 2, 0);
    rst_n = 1'b1;
    want("release_cpu_rst_n_low", 1, 0);
    tick(1);
    want("release_cpu_rst_n_high", 1, 1);
    for (int i = 0; i < 16; i++) rd(2 * i);

    // three-word program with exit timing
    enter();
    want("ld_loading", 2, 1);
    want("ld_cpu_rst_n", 1, 0);
    tick(1);
    send(8'h12); send(8'h34); send(8'hAB); send(8'hCD); send(8'h00); send(8'h01);
    want("ld3_wc", 4, 3);
    tick(1);
    load_mode = 1'b0;
    dq.push_back('{5'(m_wc), m_have_hi, m_eo});
    tick(3);
    want("exit_done_pulse", 3, 1);
    want("exit_cpu_rst_n_held", 1, 0);
    want("exit_state_run", 2, 0);
    tick(1);
    want("exit_cpu_rst_n_rel", 1, 1);
    want("exit_done_once", 3, 0);
    tick(4);
    for (int i = 0; i < 4; i++) rd(2 * i);

    // fill to full, then one overflow byte
    enter();
    pc_in = 16'h0000;
    want("load_instr_nop", 0, 32'(NOP));
    tick(1);
    for (int i = 0; i < 32; i++) send(8'($urandom));
    want("full_wc", 4, 16);
    want("full_eo_before", 6, 0);
    want("full_loading", 2, 1);
    tick(1);
    send(8'hEE);
    want("full_eo_after", 6, 1);
    want("full_wc_sat", 4, 16);
    tick(1);
    exit_session();
    for (int i = 0; i < 16; i++) rd(2 * i);

    // partial word at exit
    enter();
    for (int i = 0; i < 5; i++) send(8'($urandom));
    exit_session();
    want("partial_ep", 5, 1);
    want("partial_wc", 4, 2);
    tick(1);
    rd(0); rd(2); rd(4); rd(6);

    // exit in the same cycle as the low-byte strobe
    enter();
    send(8'h5A); send(8'hA5); send(8'h77);
    exit_with_strobe(8'h99);
    want("race_ep", 5, 1);
    want("race_wc", 4, 1);
    tick(1);
    rd(0); rd(2); rd(4);

    // strobes while running do nothing
    pulse(8'h3C);
    pulse(8'hC3);
    rd(0); rd(2); rd(4); rd(6);

    // randomized sessions
    for (int s = 0; s < 6; s++) begin
      enter();
      for (int i = $urandom_range(0, 36); i > 0; i--) send(8'($urandom));
      if ($urandom_range(0, 2) == 0) exit_with_strobe(8'($urandom));
      else exit_session();
      for (int i = 0; i < 6; i++) rd(int'($urandom_range(0, 20)) * 2);
    end

    // reset in the middle of a full, overflowed session
    enter();
    for (int i = 0; i < 33; i++) send(8'($urandom));
    want("pre_rst_eo", 6, 1);
    tick(1);
    rst_n = 1'b0;
    load_mode = 1'b0;
    m_reset();
    pc_in = 16'd32;
    want("midrst_loading", 2, 0);
    want("midrst_wc", 4, 0);
    want("midrst_ep", 5, 0);
    want("midrst_eo", 6, 0);
    want("midrst_cpu_rst_n", 1, 0);
    want("midrst_instr_pc32", 0, 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < 17; i++) rd(2 * i);

    want("scoreboard_drained", 7, 0);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
